mips_controller: RTL and testbench
==================================

MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port instr_valid, input, 1 bit, meaning the upstream instruction is valid.
REQ-004 SHALL have port instr_in, input, 32 bits, the upstream instruction word.
REQ-005 SHALL have port instr_ready, output, 1 bit, meaning the controller can accept an instruction.
REQ-006 SHALL have port Instr, output, 32 bits, the captured instruction held stable for the datapath.
REQ-007 SHALL have ports Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read and Mem_To_Reg, each output, 1 bit, the datapath control strobes.
REQ-008 SHALL have port Alu_Control, output, 3 bits, the ALU operation select.
REQ-009 SHALL have port busy, output, 1 bit, high in any state except IDLE.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle pulse on instruction retirement.

Function
REQ-011 SHALL implement FSM states IDLE, DECODE, EXEC, MEM and WB.
REQ-012 SHALL drive instr_ready high only in IDLE; accept on instr_valid&&instr_ready; on accept, latch instr_in into Instr and go to DECODE; otherwise hold IDLE.
REQ-013 SHALL decode R-type (opcode 000000) by funct: add 100000 -> ALU_ADD, sub 100010 -> ALU_SUB, and 100100 -> ALU_AND, or 100101 -> ALU_OR, slt 101010 -> ALU_SLT.
REQ-014 SHALL decode the I-type opcodes addi 001000, lw 100011 and sw 101011, all using ALU_ADD with Alu_Src=1.
REQ-015 SHALL use the Alu_Control encoding ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
REQ-016 SHALL, in DECODE, drive all strobes 0 and go to EXEC; an illegal opcode/funct goes to IDLE instead (see REQ-027/028).
REQ-017 SHALL, from entry to EXEC until leaving the instruction, hold Alu_Src, Alu_Control, Reg_Dst (1 for R-type only) and Mem_To_Reg stable; outside these states all strobes are 0 and Alu_Control=000.
REQ-018 SHALL drive Mem_To_Reg=1 (ALU result) for R-type/addi and 0 (memory data) for lw.
REQ-019 SHALL, in EXEC, go to WB for R-type and addi, and to MEM for lw and sw.
REQ-020 SHALL, in MEM for sw, assert Mem_Write for exactly one cycle, pulse done, and go to IDLE.
REQ-021 SHALL, in MEM for lw, assert Mem_Read and go to WB; Mem_Read stays high through WB.
REQ-022 SHALL, in WB, assert Reg_Write for exactly one cycle, pulse done, and go to IDLE.
REQ-023 SHALL have accept-to-done latency of 3 cycles for R-type, addi and sw, and 4 for lw; with instr_valid held high, one IDLE cycle separates consecutive instructions.
REQ-024 SHALL keep Instr unchanged while busy; instr_in/instr_valid changes while busy are ignored.

Reset
REQ-025 SHALL, while rst=0 (asynchronous, including mid-instruction), force state IDLE, Instr=0, every strobe 0, Alu_Control=000, done=0 and busy=0; instr_ready=1 once in IDLE.
REQ-026 SHALL, on reset mid-sw or mid-lw, produce no Mem_Write or Reg_Write pulse after the reset assertion; the first edge after rst rises may accept an instruction.

Configuration
REQ-027 SHALL, with MIPS_CTRL_ILLEGAL_TRAP_EN defined, add output illegal (1 bit, reset 0), pulsed one cycle in DECODE on an unsupported opcode/funct; that instruction retires to IDLE with no strobes and no done.
REQ-028 SHALL, without MIPS_CTRL_ILLEGAL_TRAP_EN, omit the illegal port and treat unsupported encodings as a NOP: DECODE -> IDLE, no strobes, done pulsed in DECODE.

Structure
REQ-029 SHALL place the ALU_* encodings, the opcode/funct constants and the FSM state encoding in shared package mips_pkg, reused by the ALU and datapath.
REQ-030 SHALL split decode into combinational sub-module mips_decoder (Instr in; alu_ctrl, alu_src, reg_dst, mem_to_reg, class, illegal out); the FSM stays in mips_controller.

Verification
REQ-031 SHALL cover: add $3,$1,$2 (0x00221820) accepted -> Reg_Write pulse exactly 3 cycles after accept, with Reg_Dst=1, Alu_Control=010, Mem_To_Reg=1.
REQ-032 SHALL cover: lw $5,8($0) (0x8C050008) -> Mem_Read high for the MEM and WB cycles, Reg_Write and done in cycle 4, Mem_To_Reg=0, Alu_Src=1.
REQ-033 SHALL cover: sw $5,4($0) (0xAC050004) -> single-cycle Mem_Write in cycle 3, Reg_Write never asserted.
REQ-034 SHALL cover: rst pulled low during MEM of sw -> Mem_Write=0 immediately, busy=0, and the next instruction accepted right after release.
REQ-035 SHALL cover: instr_valid held high with 3 queued R-type instructions -> done every 4 cycles and instr_ready low while busy.
REQ-036 SHALL cover: opcode 111111 -> illegal pulse when MIPS_CTRL_ILLEGAL_TRAP_EN is defined, NOP with done pulse when it is not, and no strobes in either build.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU operation select, opcode/funct constants, controller FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef enum logic [1:0] {
    ClsRtype = 2'd0,
    ClsAddi  = 2'd1,
    ClsLw    = 2'd2,
    ClsSw    = 2'd3
  } instr_class_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

endpackage

// File: rtl/mips_decoder.sv
// Combinational instruction decoder: maps opcode/funct to ALU select, datapath muxes and class.
module mips_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [1:0]  instr_class,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_class = ClsRtype;
    illegal     = 1'b0;
    case (opcode)
      OpRtype: begin
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
        case (funct)
          FnAdd:   alu_ctrl = ALU_ADD;
          FnSub:   alu_ctrl = ALU_SUB;
          FnAnd:   alu_ctrl = ALU_AND;
          FnOr:    alu_ctrl = ALU_OR;
          FnSlt:   alu_ctrl = ALU_SLT;
          default: illegal  = 1'b1;
        endcase
      end
      OpAddi: begin
        alu_src     = 1'b1;
        mem_to_reg  = 1'b1;
        instr_class = ClsAddi;
      end
      OpLw: begin
        alu_src     = 1'b1;
        instr_class = ClsLw;
      end
      OpSw: begin
        alu_src     = 1'b1;
        instr_class = ClsSw;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multi-cycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB) with instruction capture.
// Optional MIPS_CTRL_ILLEGAL_TRAP_EN adds an 'illegal' pulse instead of retiring bad encodings as NOP.
module mips_controller
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr_in,
  output logic        instr_ready,
  output logic [31:0] Instr,
  output logic        Reg_Dst,
  output logic        Reg_Write,
  output logic        Alu_Src,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic        Mem_To_Reg,
  output logic [2:0]  Alu_Control,
  output logic        busy,
  output logic        done
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [2:0]  dec_alu_ctrl;
  logic        dec_alu_src, dec_reg_dst, dec_mem_to_reg, dec_illegal;
  logic [1:0]  dec_class;
  logic        accept, is_lw, is_sw, in_instr;

  mips_decoder u_decoder (
    .instr       (instr_q),
    .alu_ctrl    (dec_alu_ctrl),
    .alu_src     (dec_alu_src),
    .reg_dst     (dec_reg_dst),
    .mem_to_reg  (dec_mem_to_reg),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  assign accept   = (state_q == StIdle) && instr_valid;
  assign is_lw    = (dec_class == ClsLw);
  assign is_sw    = (dec_class == ClsSw);
  assign in_instr = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr_in;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: state_d = dec_illegal ? StIdle : StExec;
      StExec:   state_d = (is_lw || is_sw) ? StMem : StWb;
      StMem:    state_d = is_sw ? StIdle : StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the registered state and the captured word, so reset clears them at once.
  always_comb begin
    Instr       = instr_q;
    instr_ready = (state_q == StIdle);
    busy        = (state_q != StIdle);
    Alu_Src     = in_instr & dec_alu_src;
    Reg_Dst     = in_instr & dec_reg_dst;
    Mem_To_Reg  = in_instr & dec_mem_to_reg;
    Alu_Control = in_instr ? dec_alu_ctrl : 3'b000;
    Mem_Write   = (state_q == StMem) && is_sw;
    Mem_Read    = is_lw && ((state_q == StMem) || (state_q == StWb));
    Reg_Write   = (state_q == StWb);
    done        = (state_q == StWb) || ((state_q == StMem) && is_sw);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    illegal     = (state_q == StDecode) && dec_illegal;
`else
    done        = done || ((state_q == StDecode) && dec_illegal);
`endif
  end

endmodule

// File: tb/tb_mips_controller.sv
// Directed self-checking bench for mips_controller with hand-computed per-cycle expectations.
module tb_mips_controller;

  logic        clk, rst, instr_valid;
  logic [31:0] instr_in, Instr;
  logic        instr_ready, Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read, Mem_To_Reg;
  logic [2:0]  Alu_Control;
  logic        busy, done;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mips_controller dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_in    (instr_in),
    .instr_ready (instr_ready),
    .Instr       (Instr),
    .Reg_Dst     (Reg_Dst),
    .Reg_Write   (Reg_Write),
    .Alu_Src     (Alu_Src),
    .Mem_Write   (Mem_Write),
    .Mem_Read    (Mem_Read),
    .Mem_To_Reg  (Mem_To_Reg),
    .Alu_Control (Alu_Control),
    .busy        (busy),
    .done        (done)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    instr_in    = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic check_idle_strobes(input string tag);
    check({tag, ":Reg_Dst"},     Reg_Dst,     0);
    check({tag, ":Reg_Write"},   Reg_Write,   0);
    check({tag, ":Alu_Src"},     Alu_Src,     0);
    check({tag, ":Mem_Write"},   Mem_Write,   0);
    check({tag, ":Mem_Read"},    Mem_Read,    0);
    check({tag, ":Mem_To_Reg"},  Mem_To_Reg,  0);
    check({tag, ":Alu_Control"}, Alu_Control, 0);
  endtask

  // Assumes the accept edge has just occurred; walks cycles 1..lat after accept.
  task automatic verify(input string name, input logic [31:0] w, input int lat,
                        input logic [2:0] alu, input logic rdst, input logic asrc,
                        input logic m2r, input logic is_lw, input logic is_sw);
    for (int c = 1; c <= lat; c++) begin
      string t;
      t = $sformatf("%s@c%0d", name, c);
      check({t, ":busy"},      busy,        1);
      check({t, ":ready"},     instr_ready, 0);
      check({t, ":Instr"},     Instr,       w);
      check({t, ":done"},      done,        32'(c == lat));
      check({t, ":Reg_Write"}, Reg_Write,   32'((c == lat) && !is_sw));
      check({t, ":Mem_Write"}, Mem_Write,   32'((c == lat) && is_sw));
      check({t, ":Mem_Read"},  Mem_Read,    32'(is_lw && c >= 3));
      if (c == 1) begin
        check({t, ":Alu_Control"}, Alu_Control, 0);
        check({t, ":Alu_Src"},     Alu_Src,     0);
        check({t, ":Reg_Dst"},     Reg_Dst,     0);
        check({t, ":Mem_To_Reg"},  Mem_To_Reg,  0);
      end else begin
        check({t, ":Alu_Control"}, Alu_Control, alu);
        check({t, ":Alu_Src"},     Alu_Src,     asrc);
        check({t, ":Reg_Dst"},     Reg_Dst,     rdst);
        check({t, ":Mem_To_Reg"},  Mem_To_Reg,  m2r);
      end
      step();
    end
    check({name, ":after:busy"},  busy,        0);
    check({name, ":after:done"},  done,        0);
    check({name, ":after:ready"}, instr_ready, 1);
    check_idle_strobes({name, ":after"});
  endtask

  task automatic run_instr(input string name, input logic [31:0] w, input int lat,
                           input logic [2:0] alu, input logic rdst, input logic asrc,
                           input logic m2r, input logic is_lw, input logic is_sw);
    issue(w);
    verify(name, w, lat, alu, rdst, asrc, m2r, is_lw, is_sw);
  endtask

  task automatic run_bad(input string name, input logic [31:0] w);
    issue(w);
    check({name, ":busy"}, busy, 1);
    check_idle_strobes({name, ":dec"});
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    check({name, ":illegal"}, illegal, 1);
    check({name, ":done"},    done,    0);
`else
    check({name, ":done"},    done,    1);
`endif
    step();
    check({name, ":after:busy"}, busy, 0);
    check({name, ":after:done"}, done, 0);
    check_idle_strobes({name, ":after"});
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    check({name, ":after:illegal"}, illegal, 0);
`endif
  endtask

  logic [31:0] ws [3];
  logic [2:0]  alus [3];

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr_in    = 32'h0;
    #3;
    check("reset:busy",  busy,        0);
    check("reset:ready", instr_ready, 1);
    check("reset:Instr", Instr,       0);
    check("reset:done",  done,        0);
    check_idle_strobes("reset");
    @(negedge clk);
    rst = 1'b1;

    run_instr("add",  32'h00221820, 3, 3'b010, 1, 0, 1, 0, 0);
    run_instr("sub",  32'h00221822, 3, 3'b110, 1, 0, 1, 0, 0);
    run_instr("and",  32'h00221824, 3, 3'b000, 1, 0, 1, 0, 0);
    run_instr("or",   32'h00221825, 3, 3'b001, 1, 0, 1, 0, 0);
    run_instr("slt",  32'h0022182A, 3, 3'b111, 1, 0, 1, 0, 0);
    run_instr("addi", 32'h20010005, 3, 3'b010, 0, 1, 1, 0, 0);
    run_instr("lw",   32'h8C050008, 4, 3'b010, 0, 1, 0, 1, 0);
    run_instr("sw",   32'hAC050004, 3, 3'b010, 0, 1, 0, 0, 1);

    run_bad("op3f",  32'hFC000000);
    run_bad("addu",  32'h00221821);

    // Reset during MEM of sw, then accept on the first edge after release.
    issue(32'hAC050004);
    step();
    step();
    check("sw_rst:pre:Mem_Write", Mem_Write, 1);
    #2 rst = 1'b0;
    #1;
    check("sw_rst:Mem_Write", Mem_Write, 0);
    check("sw_rst:busy",      busy,      0);
    check("sw_rst:done",      done,      0);
    check("sw_rst:Instr",     Instr,     0);
    check("sw_rst:ready",     instr_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    run_instr("add_after_rst", 32'h00221820, 3, 3'b010, 1, 0, 1, 0, 0);

    // Reset during MEM of lw: no Reg_Write afterwards.
    issue(32'h8C050008);
    step();
    step();
    check("lw_rst:pre:Mem_Read", Mem_Read, 1);
    #2 rst = 1'b0;
    #1;
    check("lw_rst:Mem_Read",  Mem_Read,  0);
    check("lw_rst:Reg_Write", Reg_Write, 0);
    check("lw_rst:busy",      busy,      0);
    step();
    check("lw_rst:held:Reg_Write", Reg_Write, 0);
    check("lw_rst:held:done",      done,      0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("lw_rst:rel:Reg_Write", Reg_Write, 0);
    check("lw_rst:rel:busy",      busy,      0);

    // Back-to-back with instr_valid held high; instr_in churn while busy is ignored.
    ws[0] = 32'h00221820; alus[0] = 3'b010;
    ws[1] = 32'h00221822; alus[1] = 3'b110;
    ws[2] = 32'h00221825; alus[2] = 3'b001;
    instr_in    = ws[0];
    instr_valid = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      string t;
      step();
      t = $sformatf("b2b@e%0d", e);
      check({t, ":done"},  done,        32'(e % 4 == 3));
      check({t, ":ready"}, instr_ready, 32'(e % 4 == 0));
      check({t, ":busy"},  busy,        32'(e % 4 != 0));
      if (e % 4 != 0) check({t, ":Instr"}, Instr, ws[e / 4]);
      if (e % 4 == 2) check({t, ":Alu_Control"}, Alu_Control, alus[e / 4]);
      if (e % 4 == 1) instr_in = 32'hDEADBEEF;
      if (e % 4 == 3) begin
        if (e / 4 + 1 < 3) instr_in = ws[e / 4 + 1];
        else instr_valid = 1'b0;
      end
    end
    check("b2b:end:Instr", Instr, ws[2]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
